// File: rtl/image_write.sv
// Frame-buffering BMP writer: captures one RGB888 frame in raster order, then
// streams a 24-bit bottom-up BMP file (54-byte header + padded BGR rows).
//
// Output handshake: a byte transfers on any rising edge where BYTE_VALID and
// BYTE_READY are both high. BYTE_OUT is registered and holds while
// BYTE_VALID && !BYTE_READY. The next byte is loaded on the transfer edge itself.
module image_write #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HSYNC,
  input  logic [7:0] DATA_R0,
  input  logic [7:0] DATA_G0,
  input  logic [7:0] DATA_B0,
  output logic [7:0] BYTE_OUT,
  output logic       BYTE_VALID,
  input  logic       BYTE_READY,
  output logic       WRITE_DONE,
  output logic       OVERRUN,
  output logic [1:0] dbg_state_o
);

  localparam int ROW_BYTES  = (3 * WIDTH + 3) & ~3;
  localparam int IMG_BYTES  = ROW_BYTES * HEIGHT;
  localparam int FILE_BYTES = 54 + IMG_BYTES;
  localparam int CW = $clog2(FILE_BYTES + 1);
  localparam int AW = $clog2(IMG_BYTES);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int RW = $clog2(ROW_BYTES + 1);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PIXELS  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   col_q, col_d;
  logic [YW-1:0]   row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rcol_q, rcol_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            wr_en;
  logic            xfer;
  logic [AW-1:0]   wr_addr;
  logic [CW-1:0]   rd_full;
  logic [7:0]      rd_q;
  logic [7:0]      buf_mem [IMG_BYTES];

  // Header fields are 4 bytes starting at offset 2, so (idx-2)[1:0] picks the
  // byte lane; the two 2-byte fields at 26/28 are placed in lanes 0-1 and 2-3.
  function automatic logic [7:0] hdr_byte(input logic [CW-1:0] idx);
    logic [31:0] v;
    logic [31:0] t;
    logic [CW-1:0] rel;
    rel = idx - CW'(2);
    v = 32'd0;
    if      (idx <= CW'(5))  v = 32'(FILE_BYTES);
    else if (idx <= CW'(9))  v = 32'd0;
    else if (idx <= CW'(13)) v = 32'd54;
    else if (idx <= CW'(17)) v = 32'd40;
    else if (idx <= CW'(21)) v = 32'(WIDTH);
    else if (idx <= CW'(25)) v = 32'(HEIGHT);
    else if (idx <= CW'(27)) v = 32'd1;
    else if (idx <= CW'(29)) v = 32'd24 << 16;
    else if (idx <= CW'(33)) v = 32'd0;
    else if (idx <= CW'(37)) v = 32'(IMG_BYTES);
    t = v >> {rel[1:0], 3'b000};
    if (idx == CW'(0))      hdr_byte = 8'h42;
    else if (idx == CW'(1)) hdr_byte = 8'h4D;
    else                    hdr_byte = t[7:0];
  endfunction

  assign xfer    = valid_q && BYTE_READY;
  assign wr_addr = AW'((HEIGHT - 1 - int'(row_q)) * ROW_BYTES + 3 * int'(col_q));
  // Prefetch: rd_q always holds the buffer byte that follows the one in BYTE_OUT.
  assign rd_full = cnt_d - CW'(53);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    rcol_d  = rcol_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_CAPTURE: begin
        if (HSYNC) begin
          wr_en = 1'b1;
          ovr_d = 1'b0;
          if (col_q == XW'(WIDTH - 1)) begin
            col_d = '0;
            if (row_q == YW'(HEIGHT - 1)) begin
              row_d   = '0;
              state_d = ST_HEADER;
              cnt_d   = '0;
              byte_d  = 8'h42;
              valid_d = 1'b1;
            end else begin
              row_d = row_q + YW'(1);
            end
          end else begin
            col_d = col_q + XW'(1);
          end
        end
      end
      ST_HEADER: begin
        if (HSYNC) ovr_d = 1'b1;
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(53)) begin
            state_d = ST_PIXELS;
            rcol_d  = '0;
            byte_d  = rd_q;
          end else begin
            byte_d = hdr_byte(cnt_q + CW'(1));
          end
        end
      end
      ST_PIXELS: begin
        if (HSYNC) ovr_d = 1'b1;
        if (xfer) begin
          if (cnt_q == CW'(FILE_BYTES - 1)) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            byte_d  = 8'h00;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            rcol_d = (rcol_q == RW'(ROW_BYTES - 1)) ? '0 : rcol_q + RW'(1);
            byte_d = (rcol_d < RW'(3 * WIDTH)) ? rd_q : 8'h00;
          end
        end
      end
      ST_DONE: begin
        if (HSYNC) ovr_d = 1'b1;
        state_d = ST_CAPTURE;
        cnt_d   = '0;
        col_d   = '0;
        row_d   = '0;
        rcol_d  = '0;
      end
      default: state_d = ST_CAPTURE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_CAPTURE;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      rcol_q  <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      rcol_q  <= rcol_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      buf_mem[wr_addr]          <= DATA_B0;
      buf_mem[wr_addr + AW'(1)] <= DATA_G0;
      buf_mem[wr_addr + AW'(2)] <= DATA_R0;
    end
    rd_q <= (rd_full < CW'(IMG_BYTES)) ? buf_mem[AW'(rd_full)] : 8'h00;
  end

  assign BYTE_OUT    = byte_q;
  assign BYTE_VALID  = valid_q;
  assign WRITE_DONE  = (state_q == ST_DONE);
  assign OVERRUN     = ovr_q;
  assign dbg_state_o = state_q;

endmodule
